// File: rtl/iter_alu.sv
// Multi-cycle integer ALU: single-cycle logic/arith/shift ops plus
// iterative unsigned multiply and divide with internal HI/LO registers.
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             dz
);

    localparam logic [3:0] OP_ADDU  = 4'd0;
    localparam logic [3:0] OP_SUBU  = 4'd1;
    localparam logic [3:0] OP_OR    = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLTU  = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_MULTU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_MFHI  = 4'd13;
    localparam logic [3:0] OP_MFLO  = 4'd14;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             valid_q, valid_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] alu;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   dtrial;
    logic             take;

    assign sh = a[SHW-1:0];

    always_comb begin
        alu = '0;
        case (op)
            OP_ADDU: alu = a + b;
            OP_SUBU: alu = a - b;
            OP_OR:   alu = a | b;
            OP_AND:  alu = a & b;
            OP_XOR:  alu = a ^ b;
            OP_NOR:  alu = ~(a | b);
            OP_SLTU: alu = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLT:  alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLL:  alu = b << sh;
            OP_SRL:  alu = b >> sh;
            OP_SRA:  alu = $unsigned($signed(b) >>> sh);
            OP_MFHI: alu = hi_q;
            OP_MFLO: alu = lo_q;
            default: alu = '0;
        endcase
    end

    // Multiply: {acc_hi, acc_lo} shifts right, adding the multiplicand on lsb.
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out/quotient in.
    assign msum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
    assign dtrial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opd_q};
    // A zero divisor always "subtracts", giving all-ones quotient and remainder a
    assign take   = ~dtrial[WIDTH] | dz_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opd_d    = opd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_d    = res_q;
        valid_d  = 1'b0;
        dz_d     = dz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == OP_MULTU) begin
                        state_d  = MUL;
                        cnt_d    = '1;
                        acc_hi_d = '0;
                        acc_lo_d = b;
                        opd_d    = a;
                    end else if (op == OP_DIVU) begin
                        state_d  = DIV;
                        cnt_d    = '1;
                        acc_hi_d = '0;
                        acc_lo_d = a;
                        opd_d    = b;
                        dz_d     = (b == '0);
                    end else begin
                        res_d    = alu;
                        valid_d  = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_hi_d = msum[WIDTH:1];
                acc_lo_d = {msum[0], acc_lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIN;
            end
            DIV: begin
                if (take) begin
                    acc_hi_d = dtrial[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi_d = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIN;
            end
            FIN: begin
                hi_d    = acc_hi_q;
                lo_d    = acc_lo_q;
                res_d   = acc_lo_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opd_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_q    <= '0;
            valid_q  <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opd_q    <= opd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_q    <= res_d;
            valid_q  <= valid_d;
            dz_q     <= dz_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign valid  = valid_q;
    assign result = res_q;
    assign zero   = (res_q == '0);
    assign dz     = dz_q;

endmodule
